// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory-bank port between the host (AXI4-Lite, post decode) and
//   the CNN core. Round-robin grant, registered issue to memory, and in-order
//   read returns routed back to the issuing requester through a tag FIFO.
// Ports:
//   clk_a, arstz_aq            clock, asynchronous active-low reset
//   host_* / core_*            requester side: en/we/addr/din in, gnt/dout/valid out
//   mem_en/we/addr/din         registered memory command
//   mem_dout, mem_valid        in-order memory read return
//   rd_outstanding             reads issued and not yet returned
//   err_spurious               sticky: return seen with no read in flight
module mem_port_arbiter #(
   parameter int ADDR_WIDTH      = 12,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk_a,
   input  logic                                   arstz_aq,
   input  logic                                   host_en,
   input  logic                                   host_we,
   input  logic [ADDR_WIDTH-1:0]                  host_addr,
   input  logic [DATA_WIDTH-1:0]                  host_din,
   output logic                                   host_gnt,
   output logic [DATA_WIDTH-1:0]                  host_dout,
   output logic                                   host_valid,
   input  logic                                   core_en,
   input  logic                                   core_we,
   input  logic [ADDR_WIDTH-1:0]                  core_addr,
   input  logic [DATA_WIDTH-1:0]                  core_din,
   output logic                                   core_gnt,
   output logic [DATA_WIDTH-1:0]                  core_dout,
   output logic                                   core_valid,
   output logic                                   mem_en,
   output logic                                   mem_we,
   output logic [ADDR_WIDTH-1:0]                  mem_addr,
   output logic [DATA_WIDTH-1:0]                  mem_din,
   input  logic [DATA_WIDTH-1:0]                  mem_dout,
   input  logic                                   mem_valid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   rd_outstanding,
   output logic                                   err_spurious
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   typedef enum logic {
      REQ_HOST = 1'b0,
      REQ_CORE = 1'b1
   } req_e;

   req_e                  last_gnt_q, last_gnt_d;
   req_e                  tag_q [MAX_OUTSTANDING];
   req_e                  tag_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic                  err_q, err_d;
   logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;

   logic rd_slot, host_elig, core_elig, push, pop;
   req_e head_id;

   // Read eligibility uses the registered count only: a return arriving in
   // the same cycle does not free a slot until the next cycle.
   always_comb begin
      rd_slot   = rd_cnt_q < CNT_W'(MAX_OUTSTANDING);
      host_elig = host_en & (host_we | rd_slot);
      core_elig = core_en & (core_we | rd_slot);
      host_gnt  = host_elig & (~core_elig | (last_gnt_q == REQ_CORE));
      core_gnt  = core_elig & (~host_elig | (last_gnt_q == REQ_HOST));
   end

   always_comb begin
      head_id    = tag_q[rd_ptr_q];
      pop        = mem_valid & (rd_cnt_q != '0);
      host_valid = pop & (head_id == REQ_HOST);
      core_valid = pop & (head_id == REQ_CORE);
      host_dout  = host_valid ? mem_dout : '0;
      core_dout  = core_valid ? mem_dout : '0;
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      tag_d      = tag_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      err_d      = err_q | (mem_valid & (rd_cnt_q == '0));
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      push       = 1'b0;
      if (host_gnt) begin
         last_gnt_d = REQ_HOST;
         mem_en_d   = 1'b1;
         mem_we_d   = host_we;
         mem_addr_d = host_addr;
         mem_din_d  = host_din;
         push       = ~host_we;
      end else if (core_gnt) begin
         last_gnt_d = REQ_CORE;
         mem_en_d   = 1'b1;
         mem_we_d   = core_we;
         mem_addr_d = core_addr;
         mem_din_d  = core_din;
         push       = ~core_we;
      end
      if (push) begin
         tag_d[wr_ptr_q] = last_gnt_d;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // A full FIFO cannot push (reads ineligible), so no overflow case here.
      case ({push, pop})
         2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
         2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
         default: rd_cnt_d = rd_cnt_q;
      endcase
   end

   always_ff @(posedge clk_a or negedge arstz_aq) begin
      if (!arstz_aq) begin
         last_gnt_q <= REQ_CORE;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= REQ_HOST;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_cnt_q   <= '0;
         err_q      <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         tag_q      <= tag_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_cnt_q   <= rd_cnt_d;
         err_q      <= err_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   assign mem_en         = mem_en_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_din        = mem_din_q;
   assign rd_outstanding = rd_cnt_q;
   assign err_spurious   = err_q;

endmodule
